// File: rtl/lu_compare_counter_if.sv
// Transfer channel between the 2-bit equality/difference LU and its
// downstream hit/miss counter.
//
// Handshake: a transfer happens on a rising clk edge where in_valid and
// in_ready are both 1. The source raises in_valid with lu_res/chave and
// must keep all three stable until that edge; the sink may drive in_ready
// independently of in_valid, and in_valid never depends on in_ready.
//
// Signals
//   in_valid  source -> sink  lu_res/chave carry a result
//   in_ready  sink -> source  sink accepts a transfer this cycle
//   lu_res    source -> sink  per-bit LU output, W bits
//   chave     source -> sink  LU mode: 0 = equality (XNOR), 1 = difference (XOR)
interface lu_compare_counter_if #(
  parameter int W = 2
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] lu_res;
  logic         chave;

  modport master (
    output in_valid,
    output lu_res,
    output chave,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  lu_res,
    input  chave,
    output in_ready
  );
endinterface

// File: rtl/lu_compare_counter.sv
// Reduces each LU result vector to a 1-bit verdict and counts hits and
// misses over a batch of n_ops transfers, then pulses done for one cycle.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin a batch (honoured only in IDLE)
//   n_ops       batch length, captured with start
//   bus         slave side of the LU transfer channel (in_valid/in_ready/lu_res/chave)
//   last_flag   verdict of the most recent accepted transfer
//   hit_count   transfers with verdict 1 in the current/last batch
//   miss_count  transfers with verdict 0 in the current/last batch
//   busy        high while in RUN
//   done        one-cycle pulse when the batch is complete
//   fsm_state   current FSM state encoding (IDLE=0, RUN=1, DONE=2)
module lu_compare_counter #(
  parameter int W  = 2,
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CW-1:0]        n_ops,
  lu_compare_counter_if.slave  bus,
  output logic                 last_flag,
  output logic [CW-1:0]        hit_count,
  output logic [CW-1:0]        miss_count,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] remaining_q;
  logic [W-1:0]  res;
  logic          verdict;
  logic          xfer;

  assign res = bus.lu_res;

  // Equality mode: all bits of the XNOR vector set means the operands match.
  // Difference mode: any bit of the XOR vector set means they differ.
  assign verdict = bus.chave ? (|res) : (&res);

  assign bus.in_ready = (state_q == RUN);
  assign busy         = (state_q == RUN);
  assign done         = (state_q == DONE);
  assign xfer         = bus.in_valid & bus.in_ready;
  assign fsm_state    = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // An empty batch still reports completion with a done pulse.
          state_d = (n_ops == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (xfer && (remaining_q == ONE)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining_q <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      last_flag   <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      remaining_q <= n_ops;
      hit_count   <= '0;
      miss_count  <= '0;
      last_flag   <= 1'b0;
    end else if (xfer) begin
      // Counts cannot wrap: at most n_ops transfers are accepted per batch.
      remaining_q <= remaining_q - ONE;
      last_flag   <= verdict;
      if (verdict) begin
        hit_count <= hit_count + ONE;
      end else begin
        miss_count <= miss_count + ONE;
      end
    end
  end

endmodule

// File: tb/tb_lu_compare_counter.sv
module tb_lu_compare_counter;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] n_ops;
  logic       last_flag;
  logic [7:0] hit_count;
  logic [7:0] miss_count;
  logic       busy;
  logic       done;
  logic [1:0] fsm_state;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;
  int done_cycles = 0;

  logic [0:0] exp_q[$];

  lu_compare_counter_if #(.W(2)) bus ();

  lu_compare_counter #(.W(2), .CW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n_ops      (n_ops),
    .bus        (bus),
    .last_flag  (last_flag),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Cycle monitors used by the batch tests.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (done === 1'b1) done_cycles++;
  end

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    if (rst_n === 1'b1 && bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: transfer accepted, got last_flag=%0b, required no transfer", last_flag);
      end else begin
        logic [0:0] e;
        e = exp_q.pop_front();
        if (last_flag !== e) begin
          errors++;
          $display("FAIL scoreboard_last_flag: got %0b required %0b", last_flag, e);
        end
      end
    end
  end

  // Reference verdict written from the operation meaning, not the reduction.
  function automatic logic ref_verdict(input logic c, input logic [1:0] r);
    if (c) return (r != 2'b00);   // difference: some bit differs
    else   return (r == 2'b11);   // equality: every bit matched
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [7:0] n);
    @(negedge clk);
    start = 1'b1;
    n_ops = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One transfer, then `gap` idle cycles with in_valid low. Ends at posedge+1
  // of the accepting edge when gap==0.
  task automatic send(input logic c, input logic [1:0] r, input int gap);
    int n;
    @(negedge clk);
    bus.chave    = c;
    bus.lu_res   = r;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got %0b required 1", bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(ref_verdict(c, r));
      @(posedge clk);
      #1;
      if (gap > 0) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
  endtask

  task automatic idle_bus();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (hit_count !== 8'd0)  begin errors++; $display("FAIL reset_hit: got %0d required 0", hit_count); end
    checks++; if (miss_count !== 8'd0) begin errors++; $display("FAIL reset_miss: got %0d required 0", miss_count); end
    checks++; if ({last_flag, busy, done, bus.in_ready} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags: got %b required 0000", {last_flag, busy, done, bus.in_ready}); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", fsm_state); end
    rst_n = 1'b1;
    // Async reset mid-cycle while counts are non-zero.
    do_start(8'd3);
    send(1'b0, 2'b11, 0);
    checks++; if (hit_count !== 8'd1) begin errors++; $display("FAIL pre_reset_hit: got %0d required 1", hit_count); end
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({hit_count, miss_count, last_flag, busy, done} !== 19'd0)
      begin errors++; $display("FAIL async_reset_outputs: got hit=%0d miss=%0d flags=%b required all 0", hit_count, miss_count, {last_flag, busy, done}); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL async_reset_state: got %0d required 0", fsm_state); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_equality();
    busy_cycles = 0; done_cycles = 0;
    do_start(8'd4);
    send(1'b0, 2'b11, 0);
    send(1'b0, 2'b10, 0);
    send(1'b0, 2'b01, 0);
    send(1'b0, 2'b11, 0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL eq_done_pulse: got %0b required 1", done); end
    checks++; if (hit_count !== 8'd2 || miss_count !== 8'd2)
      begin errors++; $display("FAIL eq_counts: got hit=%0d miss=%0d required hit=2 miss=2", hit_count, miss_count); end
    checks++; if (last_flag !== 1'b1) begin errors++; $display("FAIL eq_last_flag: got %0b required 1", last_flag); end
    idle_bus();
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || fsm_state !== 2'd0)
      begin errors++; $display("FAIL eq_after_done: got done=%0b state=%0d required done=0 state=0", done, fsm_state); end
    checks++; if (busy_cycles != 4) begin errors++; $display("FAIL eq_busy_cycles: got %0d required 4", busy_cycles); end
    checks++; if (done_cycles != 1) begin errors++; $display("FAIL eq_done_cycles: got %0d required 1", done_cycles); end
  endtask

  task automatic test_difference_gaps();
    int gaps[4];
    int total_gap;
    busy_cycles = 0; done_cycles = 0;
    total_gap = 0;
    for (int i = 0; i < 3; i++) begin
      gaps[i] = $urandom_range(1, 3);
      total_gap += gaps[i];
    end
    gaps[3] = 0;
    do_start(8'd4);
    send(1'b1, 2'b00, gaps[0]);
    send(1'b1, 2'b01, gaps[1]);
    send(1'b1, 2'b10, gaps[2]);
    send(1'b1, 2'b11, gaps[3]);
    checks++; if (hit_count !== 8'd3 || miss_count !== 8'd1)
      begin errors++; $display("FAIL diff_counts: got hit=%0d miss=%0d required hit=3 miss=1", hit_count, miss_count); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL diff_done_pulse: got %0b required 1", done); end
    idle_bus();
    @(posedge clk); #1;
    checks++; if (busy_cycles != 4 + total_gap)
      begin errors++; $display("FAIL diff_busy_cycles: got %0d required %0d", busy_cycles, 4 + total_gap); end
  endtask

  task automatic test_mixed_mode();
    do_start(8'd2);
    send(1'b0, 2'b11, 0);
    send(1'b1, 2'b00, 0);
    checks++; if (hit_count !== 8'd1 || miss_count !== 8'd1 || last_flag !== 1'b0)
      begin errors++; $display("FAIL mixed_result: got hit=%0d miss=%0d last=%0b required hit=1 miss=1 last=0", hit_count, miss_count, last_flag); end
    idle_bus();
  endtask

  task automatic test_not_ready();
    // Valid in IDLE must be ignored; previous batch results hold.
    @(negedge clk);
    bus.chave = 1'b0; bus.lu_res = 2'b11; bus.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL idle_in_ready: got %0b required 0", bus.in_ready); end
    checks++; if (hit_count !== 8'd1 || miss_count !== 8'd1 || last_flag !== 1'b0)
      begin errors++; $display("FAIL idle_hold_counts: got hit=%0d miss=%0d last=%0b required hit=1 miss=1 last=0", hit_count, miss_count, last_flag); end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_zero_ops();
    busy_cycles = 0; done_cycles = 0;
    do_start(8'd0);
    checks++; if (done !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL zero_done: got done=%0b busy=%0b required done=1 busy=0", done, busy); end
    checks++; if (hit_count !== 8'd0 || miss_count !== 8'd0)
      begin errors++; $display("FAIL zero_counts: got hit=%0d miss=%0d required 0 0", hit_count, miss_count); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || fsm_state !== 2'd0)
      begin errors++; $display("FAIL zero_after: got done=%0b state=%0d required 0 0", done, fsm_state); end
    checks++; if (busy_cycles != 0 || done_cycles != 1)
      begin errors++; $display("FAIL zero_cycles: got busy=%0d done=%0d required busy=0 done=1", busy_cycles, done_cycles); end
  endtask

  task automatic test_start_held();
    logic [1:0] r;
    int exp_hit;
    exp_hit = 0;
    busy_cycles = 0; done_cycles = 0;
    @(negedge clk);
    start = 1'b1;
    n_ops = 8'd3;
    @(posedge clk); #1;
    n_ops = 8'd7;   // a restart would reload 7 and clear counts
    for (int i = 0; i < 3; i++) begin
      r = 2'($urandom_range(0, 3));
      if (ref_verdict(1'b0, r)) exp_hit++;
      send(1'b0, r, 0);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL held_done: got %0b required 1", done); end
    checks++; if (hit_count !== 8'(exp_hit) || miss_count !== 8'(3 - exp_hit))
      begin errors++; $display("FAIL held_counts: got hit=%0d miss=%0d required hit=%0d miss=%0d", hit_count, miss_count, exp_hit, 3 - exp_hit); end
    @(negedge clk);
    start = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (fsm_state !== 2'd0 || busy_cycles != 3)
      begin errors++; $display("FAIL held_end: got state=%0d busy_cycles=%0d required state=0 busy_cycles=3", fsm_state, busy_cycles); end
  endtask

  task automatic test_reset_mid_batch();
    done_cycles = 0;
    do_start(8'd5);
    send(1'b0, 2'b11, 0);
    send(1'b1, 2'b00, 0);
    idle_bus();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (hit_count !== 8'd0 || miss_count !== 8'd0 || fsm_state !== 2'd0)
      begin errors++; $display("FAIL midrst_clear: got hit=%0d miss=%0d state=%0d required 0 0 0", hit_count, miss_count, fsm_state); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (done_cycles != 0) begin errors++; $display("FAIL midrst_no_done: got %0d required 0", done_cycles); end
    do_start(8'd1);
    send(1'b1, 2'b10, 0);
    checks++; if (done !== 1'b1 || hit_count !== 8'd1 || miss_count !== 8'd0 || last_flag !== 1'b1)
      begin errors++; $display("FAIL midrst_rerun: got done=%0b hit=%0d miss=%0d last=%0b required 1 1 0 1", done, hit_count, miss_count, last_flag); end
    idle_bus();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    start = 1'b0;
    n_ops = 8'd0;
    bus.in_valid = 1'b0;
    bus.lu_res = 2'b00;
    bus.chave = 1'b0;
    test_reset();
    test_equality();
    test_difference_gaps();
    test_mixed_mode();
    test_not_ready();
    test_zero_ops();
    test_start_held();
    test_reset_mid_batch();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
